cv32e40p_replica_dispatcher_ft: RTL

Parametrised replica dispatcher for the fault-tolerant EX stage. It tracks NUM_UNITS redundant functional units (ALUs or MULTs) and keeps a leaky per-unit error counter fed by voter mismatch flags. A unit is declared permanently faulty once its counter reaches THRESHOLD, or when BIST forces it faulty. From the healthy set it selects up to three units, and drives clock gating, voter slot selection and the degradation mode (TMR, DUAL, SINGLE, NONE).

---
 rtl/cv32e40p_replica_dispatcher_ft.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_replica_dispatcher_ft.sv
// Replica dispatcher for the fault-tolerant EX stage.
// Each replica owns a leaky mismatch counter and a sticky faulty flag (see the
// per-unit sub-module below). The top picks up to three healthy replicas,
// drives their clock gates and the voter slot indices, and reports the
// resulting degradation mode.

// Per-replica health tracker: leaky error counter plus sticky faulty flag.
module cv32e40p_replica_dispatcher_ft_unit #(
  parameter int CNT_W     = 4,
  parameter int THRESHOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic used_i,
  input  logic mismatch_i,
  input  logic force_i,
  input  logic clear_i,
  output logic faulty_o
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             faulty_q, faulty_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Counter/flag next state: clear wins, a faulty unit's counter is frozen,
  // and a healthy counter leaks toward zero on clean operations.
  always_comb begin
    cnt_d    = cnt_q;
    faulty_d = faulty_q;
    if (clear_i) begin
      cnt_d    = '0;
      faulty_d = 1'b0;
    end else begin
      if (used_i && !faulty_q) begin
        if (mismatch_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == THR) faulty_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      if (force_i) faulty_d = 1'b1;
    end
  end

  // Health state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      faulty_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      faulty_q <= faulty_d;
    end
  end

  assign faulty_o = faulty_q;

endmodule

module cv32e40p_replica_dispatcher_ft #(
  parameter int NUM_UNITS = 4,
  parameter int CNT_W     = 4,
  parameter int THRESHOLD = 8,
  parameter int IDX_W     = $clog2(NUM_UNITS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   unit_used_i,
  input  logic [NUM_UNITS-1:0]   mismatch_i,
  input  logic [NUM_UNITS-1:0]   force_faulty_i,
  input  logic                   clear_faults_i,
  output logic [NUM_UNITS-1:0]   clock_gate_o,
  output logic [3*IDX_W-1:0]     sel_o,
  output logic [1:0]             mode_o,
  output logic [NUM_UNITS-1:0]   permanent_faulty_o,
  output logic                   totally_defective_o,
  output logic                   reconfig_o
);

  localparam int HC_W = $clog2(NUM_UNITS + 1);

  typedef enum logic [1:0] {
    MODE_TMR    = 2'b00,
    MODE_DUAL   = 2'b01,
    MODE_SINGLE = 2'b10,
    MODE_NONE   = 2'b11
  } mode_e;

  logic [NUM_UNITS-1:0]        faulty_q;
  logic [NUM_UNITS-1:0]        faulty_prev_q, faulty_prev_d;
  logic [HC_W-1:0]             healthy_cnt;
  logic [2:0][IDX_W-1:0]       idx;
  logic [NUM_UNITS-1:0]        gate;
  mode_e                       mode;
  logic [2:0][IDX_W-1:0]       sel;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
    cv32e40p_replica_dispatcher_ft_unit #(
      .CNT_W     (CNT_W),
      .THRESHOLD (THRESHOLD)
    ) u_unit (
      .clk        (clk),
      .rst_n      (rst_n),
      .used_i     (unit_used_i),
      .mismatch_i (mismatch_i[k]),
      .force_i    (force_faulty_i[k]),
      .clear_i    (clear_faults_i),
      .faulty_o   (faulty_q[k])
    );
  end

  // Rank healthy units by index; the first three found become slots 0..2
  // and are the only ones whose clocks stay enabled.
  always_comb begin
    healthy_cnt = '0;
    idx         = '0;
    gate        = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (!faulty_q[k]) begin
        if (healthy_cnt < HC_W'(3)) begin
          idx[healthy_cnt[1:0]] = IDX_W'(k);
          gate[k]               = 1'b1;
        end
        healthy_cnt = healthy_cnt + HC_W'(1);
      end
    end
  end

  // Mode and voter slot mapping; missing slots replicate the highest
  // surviving replica so the voter sees agreeing inputs.
  always_comb begin
    mode = MODE_NONE;
    sel  = '0;
    if (healthy_cnt >= HC_W'(3)) begin
      mode = MODE_TMR;
      sel  = idx;
    end else if (healthy_cnt == HC_W'(2)) begin
      mode = MODE_DUAL;
      sel  = {idx[1], idx[1], idx[0]};
    end else if (healthy_cnt == HC_W'(1)) begin
      mode = MODE_SINGLE;
      sel  = {idx[0], idx[0], idx[0]};
    end
  end

  assign faulty_prev_d = faulty_q;

  // Previous faulty vector, used to flag the cycle a new configuration lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) faulty_prev_q <= '0;
    else        faulty_prev_q <= faulty_prev_d;
  end

  assign clock_gate_o        = gate;
  assign sel_o               = sel;
  assign mode_o              = mode;
  assign permanent_faulty_o  = faulty_q;
  assign totally_defective_o = (healthy_cnt == '0);
  assign reconfig_o          = (faulty_q != faulty_prev_q);

endmodule
